// File: rtl/pipe_stage_chain_if.sv
// rtl/pipe_stage_chain_if.sv - upstream, downstream and memory port bundle for pipe_stage_chain
interface pipe_stage_chain_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             in_mem;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic             mem_req;
   logic [WIDTH-1:0] mem_addr;
   logic             mem_resp;
   logic [WIDTH-1:0] mem_rdata;

   modport slave (
      input  in_valid, in_data, in_mem, out_ready, mem_resp, mem_rdata,
      output in_ready, out_valid, out_data, mem_req, mem_addr
   );

   modport master (
      output in_valid, in_data, in_mem, out_ready, mem_resp, mem_rdata,
      input  in_ready, out_valid, out_data, mem_req, mem_addr
   );
endinterface

// File: rtl/pipe_stage_chain.sv
// rtl/pipe_stage_chain.sv - elastic in-order pipeline with one memory-wait stage and young-stage flush
module pipe_stage_chain #(
   parameter int STAGES      = 5,
   parameter int WIDTH       = 32,
   parameter int MEM_STAGE   = 3,
   parameter int FLUSH_DEPTH = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         flush,
   pipe_stage_chain_if.slave            bus,
   output logic [STAGES-1:0]            stage_valid,
   output logic [$clog2(STAGES+1)-1:0]  occupancy
);
   localparam int OCC_W = $clog2(STAGES + 1);

   typedef enum logic [1:0] {IDLE, WAIT, DONE} mem_state_e;

   mem_state_e        state_q, state_d;
   logic [STAGES-1:0] valid_q, valid_d;
   logic [STAGES-1:0] mem_q, mem_d;
   logic [WIDTH-1:0]  data_q [STAGES];
   logic [WIDTH-1:0]  data_d [STAGES];
   logic [STAGES-1:0] load, adv;
   logic              mem_op, mem_hold, mem_fwd;
   logic [OCC_W-1:0]  occ;

   // Ready ripples from the oldest stage back; the memory stage is gated while a request is outstanding.
   always_comb begin
      mem_op   = valid_q[MEM_STAGE] && mem_q[MEM_STAGE];
      mem_hold = mem_op && (state_q != DONE) && !bus.mem_resp;
      mem_fwd  = mem_op && (state_q != DONE) && bus.mem_resp;
      adv      = '0;
      load     = '0;
      adv[STAGES-1]  = valid_q[STAGES-1] && bus.out_ready;
      load[STAGES-1] = !valid_q[STAGES-1] || adv[STAGES-1];
      for (int k = STAGES - 2; k >= 0; k--) begin
         adv[k]  = valid_q[k] && load[k+1] && !((k == MEM_STAGE) && mem_hold);
         load[k] = !valid_q[k] || adv[k];
      end
   end

   always_comb begin
      valid_d      = valid_q;
      mem_d        = mem_q;
      data_d       = data_q;
      bus.in_ready = load[0] && !flush;
      if (load[0]) begin
         valid_d[0] = bus.in_valid && bus.in_ready;
         if (valid_d[0]) begin
            data_d[0] = bus.in_data;
            mem_d[0]  = bus.in_mem;
         end
      end
      for (int k = 1; k < STAGES; k++) begin
         if (load[k]) begin
            valid_d[k] = adv[k-1];
            if (adv[k-1]) begin
               data_d[k] = ((k - 1 == MEM_STAGE) && mem_fwd) ? bus.mem_rdata : data_q[k-1];
               mem_d[k]  = mem_q[k-1];
            end
         end
      end
      // Response arrived but downstream is blocked: park the read data in place.
      if (mem_fwd && !adv[MEM_STAGE]) begin
         data_d[MEM_STAGE] = bus.mem_rdata;
      end
      if (flush) begin
         valid_d[FLUSH_DEPTH-1:0] = '0;
      end
   end

   always_comb begin
      state_d     = state_q;
      bus.mem_req = 1'b0;
      case (state_q)
         IDLE, WAIT: begin
            if (mem_op) begin
               bus.mem_req = 1'b1;
               if (bus.mem_resp) begin
                  state_d = adv[MEM_STAGE] ? IDLE : DONE;
               end else begin
                  state_d = WAIT;
               end
            end
         end
         DONE: begin
            if (adv[MEM_STAGE]) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      occ = '0;
      for (int k = 0; k < STAGES; k++) begin
         occ = occ + OCC_W'(valid_q[k]);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         valid_q <= '0;
         mem_q   <= '0;
         for (int k = 0; k < STAGES; k++) begin
            data_q[k] <= '0;
         end
      end else begin
         state_q <= state_d;
         valid_q <= valid_d;
         mem_q   <= mem_d;
         for (int k = 0; k < STAGES; k++) begin
            data_q[k] <= data_d[k];
         end
      end
   end

   assign bus.out_valid = valid_q[STAGES-1];
   assign bus.out_data  = data_q[STAGES-1];
   assign bus.mem_addr  = data_q[MEM_STAGE];
   assign stage_valid   = valid_q;
   assign occupancy     = occ;
endmodule

// File: tb/tb_pipe_stage_chain.sv
// tb/tb_pipe_stage_chain.sv - scoreboard and vector-table bench for pipe_stage_chain
module tb_pipe_stage_chain;
   localparam int          STAGES = 5;
   localparam int          WIDTH  = 32;
   localparam logic [31:0] MASK   = 32'h0000_DFAD;

   typedef struct {
      logic [31:0] data;
      logic        mem;
      int          delay;
      logic [31:0] exp_data;
      int          lat;
      int          req;
   } vec_t;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              flush = 1'b0;
   logic [STAGES-1:0] stage_valid;
   logic [2:0]        occupancy;

   pipe_stage_chain_if #(.WIDTH(WIDTH)) bus();

   pipe_stage_chain #(
      .STAGES(STAGES), .WIDTH(WIDTH), .MEM_STAGE(3), .FLUSH_DEPTH(2)
   ) dut (
      .clk(clk), .rst(rst), .flush(flush), .bus(bus.slave),
      .stage_valid(stage_valid), .occupancy(occupancy)
   );

   always #5 clk = ~clk;

   int          n_checks = 0, n_fail = 0;
   int          cycle = 0, n_out = 0, req_cnt = 0, resp_delay = 0;
   int          mem_req_cycles = 0, acc_cycle = 0, last_out_cycle = 0, occ_max = 0;
   bit          auto_mem = 1'b1, rand_delay = 1'b0, accepted = 1'b0;
   logic [31:0] sb[$];
   int          out_cycles[$];
   logic [31:0] last_out_data, last_mem_addr;
   vec_t        vecs[6];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Called at a falling edge with inputs already driven; returns at the next falling edge.
   task automatic step();
      if (auto_mem) begin
         if (bus.mem_req) begin
            if (req_cnt == resp_delay) begin
               bus.mem_resp  = 1'b1;
               bus.mem_rdata = bus.mem_addr ^ MASK;
               req_cnt       = 0;
               if (rand_delay) resp_delay = $urandom_range(0, 2);
            end else begin
               bus.mem_resp = 1'b0;
               req_cnt++;
            end
         end else begin
            bus.mem_resp = 1'b0;
            req_cnt      = 0;
         end
      end
      #1;
      if (!rst) chk("occupancy", 64'(occupancy), 64'(sb.size()));
      if (bus.mem_req) begin
         mem_req_cycles++;
         last_mem_addr = bus.mem_addr;
      end
      if (bus.out_valid && bus.out_ready) begin
         n_out++;
         last_out_cycle = cycle;
         last_out_data  = bus.out_data;
         out_cycles.push_back(cycle);
         if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sb_unexpected_beat: got %0h expected no beat", bus.out_data);
         end else begin
            chk("sb_data", 64'(bus.out_data), 64'(sb.pop_front()));
         end
      end
      if (bus.in_valid && bus.in_ready) begin
         sb.push_back(bus.in_mem ? (bus.in_data ^ MASK) : bus.in_data);
         accepted  = 1'b1;
         acc_cycle = cycle;
      end
      if (!rst && int'(occupancy) > occ_max) occ_max = int'(occupancy);
      @(posedge clk);
      @(negedge clk);
      cycle++;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic send(input logic [31:0] d, input logic m);
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      bus.in_mem   = m;
      accepted     = 1'b0;
      for (int i = 0; i < 40 && !accepted; i++) step();
      chk("send_accepted", 64'(accepted), 64'(1));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected end of test");
      $fatal(1, "watchdog");
   end

   initial begin
      int a0, a1, a2, n0, nxt;
      vecs[0] = '{32'h0000_0011, 1'b0, 0, 32'h0000_0011, 5, 0};
      vecs[1] = '{32'hA5A5_A5A5, 1'b0, 0, 32'hA5A5_A5A5, 5, 0};
      vecs[2] = '{32'h0000_0100, 1'b1, 3, 32'h0000_DEAD, 8, 4};
      vecs[3] = '{32'h0000_0200, 1'b1, 0, 32'h0000_DDAD, 5, 1};
      vecs[4] = '{32'h0000_0300, 1'b1, 1, 32'h0000_DCAD, 6, 2};
      vecs[5] = '{32'hFFFF_FFFF, 1'b0, 0, 32'hFFFF_FFFF, 5, 0};

      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.in_mem    = 1'b0;
      bus.out_ready = 1'b1;
      bus.mem_resp  = 1'b0;
      bus.mem_rdata = '0;
      run(2);
      rst = 1'b0;
      #1;
      chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
      chk("rst_out_data", 64'(bus.out_data), 64'(0));
      chk("rst_mem_req", 64'(bus.mem_req), 64'(0));
      chk("rst_occupancy", 64'(occupancy), 64'(0));
      chk("rst_in_ready", 64'(bus.in_ready), 64'(1));
      chk("rst_stage_valid", 64'(stage_valid), 64'(0));

      // single beats into an empty chain
      foreach (vecs[i]) begin
         resp_delay     = vecs[i].delay;
         req_cnt        = 0;
         mem_req_cycles = 0;
         n0             = n_out;
         send(vecs[i].data, vecs[i].mem);
         bus.in_valid = 1'b0;
         a0 = acc_cycle;
         for (int j = 0; j < 30 && n_out == n0; j++) step();
         chk("vec_seen", 64'(n_out - n0), 64'(1));
         chk("vec_latency", 64'(last_out_cycle - a0), 64'(vecs[i].lat));
         chk("vec_data", 64'(last_out_data), 64'(vecs[i].exp_data));
         chk("vec_mem_req_cycles", 64'(mem_req_cycles), 64'(vecs[i].req));
         if (vecs[i].mem) chk("vec_mem_addr", 64'(last_mem_addr), 64'(vecs[i].data));
      end

      // back-to-back burst
      occ_max = 0;
      out_cycles.delete();
      send(32'h11, 1'b0); a0 = acc_cycle;
      send(32'h22, 1'b0); a1 = acc_cycle;
      send(32'h33, 1'b0); a2 = acc_cycle;
      bus.in_valid = 1'b0;
      run(10);
      chk("burst_gap1", 64'(a1 - a0), 64'(1));
      chk("burst_gap2", 64'(a2 - a1), 64'(1));
      chk("burst_out_count", 64'(out_cycles.size()), 64'(3));
      for (int i = 0; i < 3 && i < out_cycles.size(); i++)
         chk("burst_out_cycle", 64'(out_cycles[i] - a0), 64'(5 + i));
      chk("burst_occ_peak", 64'(occ_max), 64'(3));

      // response while downstream is blocked
      resp_delay    = 1;
      req_cnt       = 0;
      bus.out_ready = 1'b0;
      send(32'hA0, 1'b0);
      send(32'h100, 1'b1);
      bus.in_valid = 1'b0;
      run(12);
      #1;
      chk("done_mem_req", 64'(bus.mem_req), 64'(0));
      chk("done_payload", 64'(bus.mem_addr), 64'(32'hDEAD));
      chk("done_stage_valid", 64'(stage_valid), 64'(5'b11000));
      chk("done_out_data", 64'(bus.out_data), 64'(32'hA0));
      bus.out_ready = 1'b1;
      run(10);
      chk("done_drained", 64'(sb.size()), 64'(0));

      // flush of a full stalled chain
      bus.out_ready = 1'b0;
      for (int i = 0; i < 5; i++) send(32'hF0 + i, 1'b0);
      bus.in_valid = 1'b0;
      #1;
      chk("fill_stage_valid", 64'(stage_valid), 64'(5'b11111));
      flush = 1'b1;
      #1;
      chk("flush_in_ready", 64'(bus.in_ready), 64'(0));
      step();
      flush = 1'b0;
      void'(sb.pop_back());
      void'(sb.pop_back());
      #1;
      chk("flush_stage_valid", 64'(stage_valid), 64'(5'b11100));
      chk("flush_occupancy", 64'(occupancy), 64'(3));
      bus.out_ready = 1'b1;
      run(10);
      chk("flush_drained", 64'(sb.size()), 64'(0));

      // reset while waiting on memory, then a stale response
      auto_mem     = 1'b0;
      bus.mem_resp = 1'b0;
      send(32'h100, 1'b1);
      bus.in_valid = 1'b0;
      run(6);
      #1;
      chk("wait_req_held", 64'(bus.mem_req), 64'(1));
      rst = 1'b1;
      step();
      rst = 1'b0;
      sb.delete();
      n0 = n_out;
      bus.mem_resp  = 1'b1;
      bus.mem_rdata = 32'hDEAD;
      step();
      bus.mem_resp = 1'b0;
      run(10);
      chk("rstwait_no_beat", 64'(n_out - n0), 64'(0));
      chk("rstwait_mem_req", 64'(bus.mem_req), 64'(0));
      chk("rstwait_occupancy", 64'(occupancy), 64'(0));
      auto_mem = 1'b1;
      req_cnt  = 0;

      // random backpressure with interleaved memory ops
      rand_delay = 1'b1;
      resp_delay = 1;
      nxt        = 0;
      n0         = n_out;
      for (int c = 0; c < 300; c++) begin
         bus.in_valid  = 1'b1;
         bus.in_data   = 32'h1000 + nxt;
         bus.in_mem    = (nxt % 4 == 3);
         bus.out_ready = 1'($urandom_range(0, 1));
         accepted      = 1'b0;
         step();
         if (accepted) nxt++;
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      run(40);
      chk("random_drained", 64'(sb.size()), 64'(0));
      chk("random_count", 64'(n_out - n0), 64'(nxt));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/pipe_stage_chain.md
PIPE_STAGE_CHAIN -- requirements
Module: pipe_stage_chain

Interface
REQ-001 SHALL have parameter STAGES, default 5, number of pipeline stages (legal 3..8); stage 0 youngest, stage STAGES-1 oldest.
REQ-002 SHALL have parameter WIDTH, default 32, payload width per stage.
REQ-003 SHALL have parameter MEM_STAGE, default 3, index of the stage that waits on memory (legal 1..STAGES-2).
REQ-004 SHALL have parameter FLUSH_DEPTH, default 2, number of youngest stages killed by flush (legal 1..MEM_STAGE).
REQ-005 SHALL have one clock and a synchronous, active-high reset: clk input 1, rising-edge clock; rst input 1, synchronous active-high reset.
REQ-006 in_valid input 1: upstream beat present.
REQ-007 in_ready output 1: chain accepts a beat this cycle.
REQ-008 in_data input WIDTH: upstream payload.
REQ-009 in_mem input 1: beat is a memory op.
REQ-010 flush input 1: branch mispredict; kill stages 0..FLUSH_DEPTH-1.
REQ-011 mem_req output 1: memory request for the op held in MEM_STAGE.
REQ-012 mem_addr output WIDTH: payload of MEM_STAGE.
REQ-013 mem_resp input 1: memory response strobe.
REQ-014 mem_rdata input WIDTH: response data.
REQ-015 out_valid output 1: stage STAGES-1 valid.
REQ-016 out_ready input 1: downstream accepts.
REQ-017 out_data output WIDTH: stage STAGES-1 payload.
REQ-018 stage_valid output STAGES: per-stage valid bits.
REQ-019 occupancy output clog2(STAGES+1): count of valid stages.

Function
REQ-020 Each stage SHALL hold valid, mem flag and WIDTH payload; stage k SHALL load from stage k-1 when it is empty or advancing; stage k advances when valid and stage k+1 loads (oldest: out_ready).
REQ-021 in_ready SHALL equal (stage 0 empty or advancing) and not flush; a beat is accepted when in_valid and in_ready.
REQ-022 Non-mem beat into an empty, unstalled chain: accepted cycle t, out_valid high in cycle t+STAGES, out_data equals in_data.
REQ-023 Memory FSM SHALL have states IDLE, WAIT, DONE; reset state IDLE.
REQ-024 IDLE: if stage MEM_STAGE valid and mem flag set, mem_req=1 combinationally; state becomes WAIT next cycle unless mem_resp is high that same cycle.
REQ-025 WAIT: mem_req=1; stage MEM_STAGE SHALL NOT advance until mem_resp.
REQ-026 On mem_resp in IDLE-with-request or WAIT: stage MEM_STAGE advances that cycle if stage MEM_STAGE+1 loads, forwarding mem_rdata as payload, and FSM goes IDLE; otherwise payload of MEM_STAGE is replaced by mem_rdata and FSM goes DONE.
REQ-027 DONE: mem_req=0; stage advances when downstream loads, then FSM goes IDLE.
REQ-028 mem_resp while no request is pending SHALL be ignored.
REQ-029 Non-mem ops in MEM_STAGE SHALL pass with no extra latency; mem_req=0.
REQ-030 flush SHALL clear valid of stages 0..FLUSH_DEPTH-1 at the next edge, overriding any load into them; stages >= FLUSH_DEPTH continue normally the same cycle.
REQ-031 Flush plus stall the same cycle: flushed stages empty, older stages hold.
REQ-032 Invalid stages SHALL NOT update payload (hold last value).
REQ-033 occupancy SHALL equal popcount(stage_valid) every cycle; range 0..STAGES.
REQ-034 Full chain with out_ready=1 and in_valid=1 SHALL sustain one beat per cycle.

Reset
REQ-035 While rst is high at an edge: all valid bits 0, payloads 0, FSM IDLE; therefore out_valid=0, out_data=0, mem_req=0, occupancy=0, in_ready=1 after the edge.
REQ-036 Reset mid-memory-op SHALL drop the op; mem_resp arriving after reset SHALL be ignored.

Verification
REQ-037 STAGES=5: beats 0x11,0x22,0x33 on consecutive cycles from cycle 1, out_ready=1 -> out_data 0x11,0x22,0x33 in cycles 6,7,8; occupancy peaks at 3.
REQ-038 Mem beat addr 0x100, mem_resp after 3 cycles with rdata 0xDEAD -> mem_req high 4 cycles, mem_addr=0x100, out_data=0xDEAD, out_valid 3 cycles later than a non-mem beat.
REQ-039 mem_resp while out_ready=0 and chain full downstream -> FSM DONE, mem_req=0, 0xDEAD held; out_ready=1 -> drains in order.
REQ-040 Stages 0..4 full, flush=1 one cycle -> stage_valid 5'b11100 after edge, occupancy=3, in_ready=0 during flush.
REQ-041 rst during WAIT, then mem_resp=1 -> no output beat, mem_req=0, occupancy=0.
REQ-042 Full chain, out_ready toggling 1/0 random, in_valid=1 -> no beat lost or duplicated, order preserved.
